// File: rtl/buffer_mode_ctrl_if.sv
// rtl/buffer_mode_ctrl_if.sv - Control, sample stream and side-band bundle for buffer_mode_ctrl
interface buffer_mode_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
);
  logic                    start;
  logic [2:0]              mode;
  logic [LEN_W-1:0]        length;
  logic                    in_valid;
  logic signed [WIDTH-1:0] in_data;
  logic                    in_ready;
  logic [1:0]              S5;
  logic [1:0]              S6;
  logic signed [WIDTH-1:0] buf_data;
  logic                    out_valid;
  logic                    out_last;
  logic                    busy;
  logic                    done;
  logic                    cfg_err;

  modport master (
    output start, mode, length, in_valid, in_data,
    input  in_ready, S5, S6, buf_data, out_valid, out_last, busy, done, cfg_err
  );

  modport slave (
    input  start, mode, length, in_valid, in_data,
    output in_ready, S5, S6, buf_data, out_valid, out_last, busy, done, cfg_err
  );
endinterface

// File: rtl/buffer_mode_ctrl.sv
// rtl/buffer_mode_ctrl.sv - Layer-mode sequencer feeding ControlBuffer with aligned valid/last side-band
module buffer_mode_ctrl #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
) (
  input logic               clk,
  input logic               rst,
  buffer_mode_ctrl_if.slave bus
);
  // Deepest ControlBuffer delay; the side-band line must cover it.
  localparam int DEPTH = 54;

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;
  state_t state_q, state_d;

  logic                    dec_legal;
  logic [1:0]              dec_s5;
  logic [1:0]              dec_s6;
  logic [5:0]              dec_tap;
  logic [LEN_W-1:0]        len_q;
  logic [LEN_W-1:0]        cnt_q;
  logic [5:0]              tap_q;
  logic [1:0]              s5_q;
  logic [1:0]              s6_q;
  logic signed [WIDTH-1:0] data_q;
  logic                    bv_q;
  logic                    bl_q;
  logic                    cfg_err_q;
  logic [DEPTH-1:0]        vld_sr;
  logic [DEPTH-1:0]        lst_sr;
  logic                    start_ok;
  logic                    start_bad;
  logic                    accept;
  logic                    last_accept;
  logic                    out_last_w;

  // Mode decode: delay selects plus the side-band tap index, which is D-1
  always_comb begin
    dec_legal = 1'b1;
    dec_s5    = 2'b00;
    dec_s6    = 2'b00;
    dec_tap   = 6'd20;
    case (bus.mode)
      3'd0: dec_tap = 6'd20;
      3'd1: begin dec_s5 = 2'b01; dec_tap = 6'd35; end
      3'd2: begin dec_s5 = 2'b10; dec_tap = 6'd53; end
      3'd3: begin dec_s6 = 2'b01; dec_tap = 6'd5;  end
      4'd4: begin dec_s6 = 2'b10; dec_tap = 6'd17; end
      3'd5: begin dec_s6 = 2'b11; dec_tap = 6'd20; end
      default: dec_legal = 1'b0;
    endcase
  end

  assign start_ok    = (state_q == IDLE) && bus.start && dec_legal && (bus.length != '0);
  assign start_bad   = (state_q == IDLE) && bus.start && !(dec_legal && (bus.length != '0));
  assign accept      = (state_q == STREAM) && bus.in_valid;
  assign last_accept = accept && ((cnt_q + LEN_W'(1)) == len_q);
  assign out_last_w  = lst_sr[tap_q];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: DRAIN waits for the last sample to reach the buffer output
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = LOAD;
      LOAD:    state_d = STREAM;
      STREAM:  if (last_accept) state_d = DRAIN;
      DRAIN:   if (out_last_w) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Burst configuration latched on an accepted start; S5/S6 persist into IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s5_q  <= 2'b00;
      s6_q  <= 2'b00;
      tap_q <= 6'd0;
      len_q <= '0;
      cnt_q <= '0;
    end else if (start_ok) begin
      s5_q  <= dec_s5;
      s6_q  <= dec_s6;
      tap_q <= dec_tap;
      len_q <= bus.length;
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + LEN_W'(1);
    end
  end

  // Sample register into ControlBuffer; idle cycles push zeros with bv=0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      bv_q   <= 1'b0;
      bl_q   <= 1'b0;
    end else begin
      data_q <= accept ? bus.in_data : '0;
      bv_q   <= accept;
      bl_q   <= last_accept;
    end
  end

  // Side-band delay line; flushed on a new burst so leftovers never hit a deeper tap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr <= '0;
      lst_sr <= '0;
    end else if (start_ok) begin
      vld_sr <= '0;
      lst_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[DEPTH-2:0], bv_q};
      lst_sr <= {lst_sr[DEPTH-2:0], bl_q};
    end
  end

  // Rejected start reported one cycle later
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= start_bad;
  end

  assign bus.in_ready  = (state_q == STREAM);
  assign bus.busy      = (state_q == LOAD) || (state_q == STREAM) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);
  assign bus.cfg_err   = cfg_err_q;
  assign bus.S5        = s5_q;
  assign bus.S6        = s6_q;
  assign bus.buf_data  = data_q;
  assign bus.out_valid = vld_sr[tap_q];
  assign bus.out_last  = out_last_w;
endmodule

// File: tb/tb_buffer_mode_ctrl.sv
// tb/tb_buffer_mode_ctrl.sv - Randomized self-checking bench for buffer_mode_ctrl
module tb_buffer_mode_ctrl;
  localparam int WIDTH = 32;
  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst;

  buffer_mode_ctrl_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();
  buffer_mode_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int d_tab  [6] = '{21, 36, 54, 6, 18, 21};
  int s5_tab [6] = '{0, 1, 2, 0, 0, 0};
  int s6_tab [6] = '{0, 0, 0, 1, 2, 3};

  int          cur_s5 = 0;
  int          cur_s6 = 0;
  int          valid_pat[$];
  logic [31:0] data_pat[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s5"},        32'(bus.S5), 32'd0);
    chk({tag, "_s6"},        32'(bus.S6), 32'd0);
    chk({tag, "_buf_data"},  bus.buf_data, 32'd0);
    chk({tag, "_in_ready"},  32'(bus.in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_out_last"},  32'(bus.out_last), 32'd0);
    chk({tag, "_busy"},      32'(bus.busy), 32'd0);
    chk({tag, "_done"},      32'(bus.done), 32'd0);
    chk({tag, "_cfg_err"},   32'(bus.cfg_err), 32'd0);
  endtask

  // One burst: the model tracks accepts per edge (relative to the start edge)
  // and derives every expected output from the delay D and the timing rules.
  task automatic run_burst(input int m, input int len, input int gap_pct,
                           input bit incr, input bit poke_start);
    int          d;
    int          nacc;
    int          r;
    int          last_r;
    int          first_acc;
    int          first_ov;
    bit          fin;
    bit          iv;
    bit          ready_exp;
    bit          exp_ov;
    bit          exp_ol;
    bit          acc [0:4095];
    bit          lst [0:4095];
    logic [31:0] dat [0:4095];
    logic [31:0] obs [0:4095];
    logic [31:0] exp_q[$];
    logic [31:0] base;
    logic [31:0] din;

    d         = d_tab[m];
    base      = $urandom;
    nacc      = 0;
    last_r    = -1;
    first_acc = -1;
    first_ov  = -1;

    chk("idle_busy", 32'(bus.busy), 32'd0);
    bus.start  = 1'b1;
    bus.mode   = 3'(m);
    bus.length = 16'(len);
    tick();
    bus.start  = 1'b0;
    bus.mode   = 3'($urandom_range(0, 7));
    bus.length = 16'($urandom);
    cur_s5 = s5_tab[m];
    cur_s6 = s6_tab[m];
    chk("load_s5", 32'(bus.S5), 32'(cur_s5));
    chk("load_s6", 32'(bus.S6), 32'(cur_s6));
    chk("load_busy", 32'(bus.busy), 32'd1);
    chk("load_buf", bus.buf_data, 32'd0);
    acc[0] = 1'b0;
    lst[0] = 1'b0;
    obs[0] = bus.buf_data;

    r   = 1;
    fin = 1'b0;
    while (!fin) begin
      ready_exp = (r >= 2) && (nacc < len);
      chk("in_ready", 32'(bus.in_ready), 32'(ready_exp));
      if (valid_pat.size() > 0 && ready_exp) iv = (valid_pat.pop_front() != 0);
      else                                   iv = ($urandom_range(0, 99) >= gap_pct);
      if (data_pat.size() > 0 && iv && ready_exp) din = data_pat.pop_front();
      else if (incr)                               din = base + 32'(nacc);
      else                                         din = $urandom;
      bus.in_valid = iv;
      bus.in_data  = din;
      if (poke_start) begin
        bus.start  = (r == 5);
        bus.mode   = 3'((m + 1) % 6);
        bus.length = 16'd7;
      end
      acc[r] = iv && ready_exp;
      dat[r] = din;
      lst[r] = 1'b0;
      if (acc[r]) begin
        if (first_acc < 0) first_acc = r;
        nacc++;
        exp_q.push_back(din);
        if (nacc == len) begin
          lst[r] = 1'b1;
          last_r = r;
        end
      end

      tick();
      obs[r] = bus.buf_data;
      chk("buf_data", bus.buf_data, acc[r] ? dat[r] : 32'd0);
      exp_ov = (r >= d) ? acc[r-d] : 1'b0;
      exp_ol = (r >= d) ? lst[r-d] : 1'b0;
      chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      chk("out_last", 32'(bus.out_last), 32'(exp_ol));
      if (bus.out_valid === 1'b1) begin
        if (first_ov < 0) first_ov = r;
        if (r >= d && exp_q.size() > 0) chk("cb_data_out", obs[r-d], exp_q.pop_front());
        else                             chk("cb_spurious_valid", 32'(bus.out_valid), 32'd0);
      end
      chk("done", 32'(bus.done), 32'((last_r >= 0) && (r == last_r + d + 1)));
      chk("busy", 32'(bus.busy), 32'(!((last_r >= 0) && (r > last_r + d))));
      chk("hold_s5", 32'(bus.S5), 32'(cur_s5));
      chk("hold_s6", 32'(bus.S6), 32'(cur_s6));
      chk("no_cfg_err", 32'(bus.cfg_err), 32'd0);
      if ((last_r >= 0) && (r == last_r + d + 1)) fin = 1'b1;
      r++;
      if (r > 4000) begin
        chk("burst_bound", 32'(r), 32'd0);
        fin = 1'b1;
      end
    end

    chk("first_valid_latency", 32'(first_ov - first_acc), 32'(d));
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    bus.start    = 1'b0;
    tick();
    chk("post_busy", 32'(bus.busy), 32'd0);
    chk("post_done", 32'(bus.done), 32'd0);
    chk("post_in_ready", 32'(bus.in_ready), 32'd0);
    chk("post_buf", bus.buf_data, 32'd0);
    chk("post_s5", 32'(bus.S5), 32'(cur_s5));
    chk("post_s6", 32'(bus.S6), 32'(cur_s6));
  endtask

  task automatic bad_start(input int m, input int len, input string tag);
    bus.start  = 1'b1;
    bus.mode   = 3'(m);
    bus.length = 16'(len);
    tick();
    bus.start = 1'b0;
    chk({tag, "_cfg_err"}, 32'(bus.cfg_err), 32'd1);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_s5"}, 32'(bus.S5), 32'(cur_s5));
    chk({tag, "_s6"}, 32'(bus.S6), 32'(cur_s6));
    tick();
    chk({tag, "_cfg_err_clear"}, 32'(bus.cfg_err), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.mode     = 3'd0;
    bus.length   = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    data_pat = '{32'd10, -32'sd20, 32'd30, -32'sd40};
    run_burst(3, 4, 0, 1'b0, 1'b0);

    bad_start(6, 5, "mode6");
    bad_start(7, 9, "mode7");
    bad_start(2, 0, "len0");

    valid_pat = '{1, 0, 0, 1, 1};
    run_burst(2, 3, 50, 1'b0, 1'b0);

    for (int m = 0; m < 6; m++) run_burst(m, 60, 0, 1'b1, 1'b0);

    run_burst(4, 10, 30, 1'b0, 1'b1);

    run_burst(1, 12, 0, 1'b0, 1'b0);
    run_burst(4, 12, 20, 1'b0, 1'b0);

    run_burst(0, 1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) run_burst($urandom_range(0, 5), $urandom_range(1, 40), 30, 1'b0, 1'b0);

    bus.start  = 1'b1;
    bus.mode   = 3'd2;
    bus.length = 16'd30;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    repeat (10) begin
      bus.in_data = $urandom;
      tick();
    end
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("async_reset");
    tick();
    rst = 1'b0;
    cur_s5 = 0;
    cur_s6 = 0;
    for (int i = 0; i < 70; i++) begin
      tick();
      chk("rst_no_done", 32'(bus.done), 32'd0);
      chk("rst_no_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_idle", 32'(bus.busy), 32'd0);
      chk("rst_no_accept", bus.buf_data, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/buffer_mode_ctrl.md
# buffer_mode_ctrl

Upstream sequencing stage for ControlBuffer in the ECG CNN datapath. Per layer it decodes a layer mode into the buffer's S5/S6 delay selects and streams a fixed-length burst of samples into the buffer's data input. It also generates a valid/last side-band that is cycle-aligned with ControlBuffer's data_out, so downstream stages know which buffer outputs are real samples.

## Interface
- WIDTH, 32: sample width in bits, signed; must match ControlBuffer WIDTH.
- LEN_W, 16: width of the burst-length port.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- mode  in  3  layer mode; sampled with start.
- length  in  LEN_W  samples in the burst; sampled with start.
- in_valid  in  1  in_data carries a sample.
- in_data  in  WIDTH  signed sample.
- in_ready  out  1  high only in STREAM; a sample is accepted on a rising edge where in_valid && in_ready.
- S5, S6  out  2 each  delay selects to ControlBuffer.
- buf_data  out  WIDTH  registered sample to ControlBuffer data_in.
- out_valid  out  1  ControlBuffer data_out holds an accepted sample this cycle.
- out_last  out  1  that sample is the burst's last.
- busy  out  1  high in LOAD, STREAM and DRAIN.
- done  out  1  one-cycle pulse at burst completion.
- cfg_err  out  1  one-cycle pulse on a rejected start.

## Operation
- Mode decode ({S6,S5}, delay D):
  - 0: 00,00, D=21
  - 1: 00,01, D=36
  - 2: 00,10, D=54
  - 3: 01,00, D=6
  - 4: 10,00, D=18
  - 5: 11,00, D=21
  - 6 and 7 are illegal.
- FSM states are IDLE, LOAD, STREAM, DRAIN and DONE.
- IDLE:
  - start with a legal mode and length≠0 goes to LOAD. It latches mode, length and D, and drives S5/S6.
  - start with an illegal mode or length=0 pulses cfg_err the next cycle and stays in IDLE. S5/S6 are unchanged.
- LOAD: one cycle, so the ControlBuffer mux settles before any data arrives. Then go to STREAM.
- STREAM:
  - Each accepted sample is registered into buf_data and sets an internal flag bv=1 for that cycle.
  - Cycles with no accept drive buf_data=0 and bv=0.
  - The accept count is 16-bit. When the count reaches length, go to DRAIN in the same edge.
- DRAIN:
  - buf_data=0 and bv=0; in_valid is ignored.
  - Leave for DONE on the cycle out_last is high.
- DONE: done=1 for one cycle, then IDLE.
- Valid/last alignment:
  - A 54-deep shift register carries {bv, bl}, where bl=bv on the final sample.
  - out_valid/out_last at cycle t equal bv/bl at cycle t−D, using tap D−1.
- S5/S6 hold from LOAD through DONE, and keep the last config in IDLE.
- start while busy is ignored: no error and no relatch.
- in_valid outside STREAM is ignored and not accepted.

## Timing
- Reset values:
  - S5=S6=00, buf_data=0.
  - in_ready, out_valid, out_last, busy, done and cfg_err all 0.
  - FSM in IDLE, counters and shift register cleared.
- If start is sampled at edge k:
  - LOAD occupies cycle k+1.
  - in_ready=1 from cycle k+2.
- in_data accepted at edge n appears on buf_data in cycle n+1 (1-cycle latency).
- That sample appears at ControlBuffer data_out, with out_valid=1, in cycle n+1+D.
- Gaps in in_valid propagate as out_valid=0 gaps with identical spacing.
- done pulses the cycle after out_last.
- Total from first accept to done, gap-free: length+D+1 cycles.
- Reset mid-burst:
  - Immediate asynchronous return to reset values; in-flight valid bits are discarded.
  - ControlBuffer contents are not tracked.
- length=1: the same sample carries out_valid and out_last.

## Test plan
- Reset: assert rst mid-STREAM for mode 2 → all outputs 0 asynchronously, IDLE on release, no done pulse.
- Mode 3 burst: length=4, samples 10,−20,30,−40 gap-free, first accept at edge n:
  - out_valid high cycles n+7..n+10;
  - ControlBuffer data_out = 10,−20,30,−40;
  - out_last at n+10, done at n+11.
- Mode 2 with gaps: length=3, in_valid pattern 1,0,0,1,1 → out_valid pattern 1,0,0,1,1 beginning 55 cycles after the first accept; data matches inputs.
- Sweep modes 0–5, each with length=60 and incrementing data:
  - S5/S6 match the decode table;
  - measured first-valid latency = D+1 after the first accept;
  - all 60 samples match.
- Error and robustness:
  - start with mode=6 → cfg_err pulse, S5/S6 unchanged.
  - start with length=0 → cfg_err pulse, S5/S6 unchanged.
  - start during a burst → ignored, burst completes normally.
  - in_valid in IDLE/DRAIN → no accept.
- Back-to-back bursts: mode 1 then mode 4, start asserted the cycle after done → S5/S6 change only in the second LOAD, second burst output correct.
